// File: rtl/modular_square_iter_ctrl.sv
// VDF evaluation loop controller: formats the operand, runs a programmable
// number of back-to-back squarings on an external core, returns the result.
module modular_square_iter_ctrl #(
    parameter int MOD_LEN               = 1024,
    parameter int WORD_LEN              = 16,
    parameter int BIT_LEN               = 17,
    parameter int REDUNDANT_ELEMENTS    = 2,
    parameter int NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
    parameter int NUM_ELEMENTS          = NONREDUNDANT_ELEMENTS + REDUNDANT_ELEMENTS,
    parameter int IO_STAGES             = 3,
    parameter int ITER_W                = 40,
    parameter int CORE_TIMEOUT          = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [ITER_W-1:0]               iterations,
    input  logic [MOD_LEN-1:0]              sq_in,
    input  logic                            abort,
    output logic                            busy,
    output logic                            valid,
    output logic [NUM_ELEMENTS*32-1:0]      sq_out,
    output logic [ITER_W-1:0]               iter_done,
    output logic                            error,
    output logic                            core_start,
    output logic [NUM_ELEMENTS*BIT_LEN-1:0] core_sq_in,
    input  logic [NUM_ELEMENTS*BIT_LEN-1:0] core_sq_out,
    input  logic                            core_valid
);

    localparam int OPW  = NUM_ELEMENTS * BIT_LEN;
    localparam int OUTW = NUM_ELEMENTS * 32;
    localparam int TW   = (CORE_TIMEOUT > 1) ? $clog2(CORE_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST =
        TW'((CORE_TIMEOUT > 0) ? CORE_TIMEOUT - 1 : 0);
    localparam int LAST = IO_STAGES - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state;
    logic [ITER_W-1:0]   iter_q;
    logic [OPW-1:0]      op_q;
    logic [TW-1:0]       wait_cnt;

    logic [IO_STAGES-1:0] pipe_vld;
    logic [ITER_W-1:0]    pipe_it [IO_STAGES];
    logic [MOD_LEN-1:0]   pipe_op [IO_STAGES];

    logic              accept;
    logic              kill;
    logic              last_iter;
    logic              timed_out;
    logic [ITER_W-1:0] iter_inc;

    function automatic logic [OPW-1:0] fmt(input logic [MOD_LEN-1:0] x);
        logic [OPW-1:0] v;
        v = '0;
        for (int j = 0; j < NONREDUNDANT_ELEMENTS; j++)
            v[BIT_LEN*j +: BIT_LEN] = BIT_LEN'(x[WORD_LEN*j +: WORD_LEN]);
        return v;
    endfunction

    function automatic logic [OUTW-1:0] widen(input logic [OPW-1:0] v);
        logic [OUTW-1:0] w;
        w = '0;
        for (int j = 0; j < NUM_ELEMENTS; j++)
            w[32*j +: 32] = 32'(v[BIT_LEN*j +: BIT_LEN]);
        return w;
    endfunction

    assign accept     = start && !busy;
    assign kill       = abort && (state != S_IDLE || |pipe_vld);
    assign iter_inc   = iter_done + ITER_W'(1);
    assign last_iter  = iter_inc == iter_q;
    assign timed_out  = (CORE_TIMEOUT != 0) && (wait_cnt == TO_LAST);
    assign core_sq_in = op_q;

    // Start flag, count and operand travel together; abort kills only the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < IO_STAGES; i++) begin
                pipe_it[i] <= '0;
                pipe_op[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept && !kill;
            if (accept) begin
                pipe_it[0] <= iterations;
                pipe_op[0] <= sq_in;
            end
            for (int i = 1; i < IO_STAGES; i++) begin
                pipe_vld[i] <= pipe_vld[i-1] && !kill;
                pipe_it[i]  <= pipe_it[i-1];
                pipe_op[i]  <= pipe_op[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            iter_q     <= '0;
            op_q       <= '0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            sq_out     <= '0;
            iter_done  <= '0;
            error      <= 1'b0;
            core_start <= 1'b0;
        end else begin
            core_start <= 1'b0;
            valid      <= 1'b0;
            if (accept) begin
                busy      <= 1'b1;
                iter_done <= '0;
                error     <= 1'b0;
            end
            if (kill) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (pipe_vld[LAST]) begin
                            op_q   <= fmt(pipe_op[LAST]);
                            iter_q <= pipe_it[LAST];
                            if (pipe_it[LAST] == '0) begin
                                state  <= S_DONE;
                                valid  <= 1'b1;
                                sq_out <= widen(fmt(pipe_op[LAST]));
                            end else begin
                                state      <= S_ISSUE;
                                core_start <= 1'b1;
                            end
                        end
                    end
                    S_ISSUE: begin
                        state    <= S_WAIT;
                        wait_cnt <= '0;
                    end
                    S_WAIT: begin
                        if (core_valid) begin
                            op_q      <= core_sq_out;
                            iter_done <= iter_inc;
                            if (last_iter) begin
                                state  <= S_DONE;
                                valid  <= 1'b1;
                                sq_out <= widen(core_sq_out);
                            end else begin
                                state      <= S_ISSUE;
                                core_start <= 1'b1;
                            end
                        end else if (timed_out) begin
                            state <= S_IDLE;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + TW'(1);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_modular_square_iter_ctrl.sv
// Randomized bench for modular_square_iter_ctrl with a behavioural squaring
// core and a cycle-level reference model of the controller's outputs.
module tb_modular_square_iter_ctrl;

    localparam int TO  = 16;
    localparam int BIG = 1 << 30;
    localparam logic [63:0] M = 64'hFFFF_FFFF_FFFF_FFC5;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [39:0]  iterations;
    logic [63:0]  sq_in;
    logic         abort;
    logic         busy;
    logic         valid;
    logic [191:0] sq_out;
    logic [39:0]  iter_done;
    logic         error;
    logic         core_start;
    logic [101:0] core_sq_in;
    logic [101:0] core_sq_out;
    logic         core_valid;

    modular_square_iter_ctrl #(
        .MOD_LEN(64), .WORD_LEN(16), .BIT_LEN(17), .REDUNDANT_ELEMENTS(2),
        .IO_STAGES(3), .ITER_W(40), .CORE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .iterations(iterations),
        .sq_in(sq_in), .abort(abort), .busy(busy), .valid(valid),
        .sq_out(sq_out), .iter_done(iter_done), .error(error),
        .core_start(core_start), .core_sq_in(core_sq_in),
        .core_sq_out(core_sq_out), .core_valid(core_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Model of the current job.
    int           j_t0 = -100;
    int           j_n = 0;
    int           j_lat = 1;
    bit           j_never = 1'b0;
    int           j_kind = 0;
    int           j_cut = BIG;
    logic [63:0]  j_x = '0;
    logic [191:0] last_sq = '0;
    logic [101:0] last_resp = '0;
    int           vcyc = -1;
    int           cs_cnt = 0;

    // Core model state.
    int           core_lat = 1;
    int           spur_at = -1;
    bit           pend = 1'b0;
    int           pend_due = 0;
    logic [101:0] pend_op = '0;

    task automatic chk(input string nm, input logic [191:0] act,
                       input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] val_op(input logic [101:0] op);
        logic [127:0] s;
        s = '0;
        for (int j = 0; j < 6; j++)
            s = s + (128'(op[17*j +: 17]) << (16 * j));
        return s;
    endfunction

    function automatic logic [127:0] red(input logic [191:0] w);
        logic [127:0] s;
        s = '0;
        for (int j = 0; j < 6; j++)
            s = s + (128'(w[32*j +: 32]) << (16 * j));
        return s;
    endfunction

    function automatic logic [191:0] fmt(input logic [63:0] x);
        logic [191:0] w;
        w = '0;
        for (int j = 0; j < 4; j++)
            w[32*j +: 32] = 32'(x[16*j +: 16]);
        return w;
    endfunction

    function automatic logic [191:0] widen(input logic [101:0] op);
        logic [191:0] w;
        w = '0;
        for (int j = 0; j < 6; j++)
            w[32*j +: 32] = 32'(op[17*j +: 17]);
        return w;
    endfunction

    function automatic logic [63:0] pw(input logic [63:0] x, input int n);
        logic [63:0] r;
        r = x;
        for (int i = 0; i < n; i++)
            r = 64'((128'(r) * 128'(r)) % 128'(M));
        return r;
    endfunction

    // Core output in redundant form: random borrows into the 17th bit.
    function automatic logic [101:0] enc(input logic [63:0] r);
        logic [16:0]  c [6];
        logic [101:0] o;
        for (int j = 0; j < 4; j++) c[j] = 17'(r[16*j +: 16]);
        c[4] = '0;
        c[5] = '0;
        for (int j = 0; j < 3; j++) begin
            if (c[j+1] != '0 && $urandom_range(0, 1) == 1) begin
                c[j]   = c[j] + 17'h10000;
                c[j+1] = c[j+1] - 17'd1;
            end
        end
        o = '0;
        for (int j = 0; j < 6; j++) o[17*j +: 17] = c[j];
        return o;
    endfunction

    always @(negedge clk) begin : core_model
        logic [127:0] g;
        logic [127:0] vv;
        g = {$urandom, $urandom, $urandom, $urandom};
        core_valid = 1'b0;
        core_sq_out = g[101:0];
        if (reset && core_start) begin
            pend     = core_lat != 0;
            pend_due = cyc + core_lat;
            pend_op  = core_sq_in;
        end
        if (pend && cyc == pend_due) begin
            vv = val_op(pend_op) % 128'(M);
            core_sq_out = enc(64'((vv * vv) % 128'(M)));
            last_resp = core_sq_out;
            core_valid = 1'b1;
            pend = 1'b0;
        end else if (cyc == spur_at) begin
            core_valid = 1'b1;
        end
    end

    always @(negedge clk) begin : monitor
        int v, lim, step, ncs, d, cnt, r;
        logic e_valid, e_busy, e_cs, e_err;
        logic [191:0] e_sq;
        #1;
        step = j_lat + 1;
        ncs = j_never ? ((j_n > 0) ? 1 : 0) : j_n;
        v = (j_never && j_n > 0) ? BIG : j_t0 + 4 + j_n * step;
        lim = (v < j_cut) ? v : j_cut;
        e_valid = cyc == v && v < j_cut;
        e_busy = cyc > j_t0 && cyc <= lim;
        d = cyc - (j_t0 + 4);
        e_cs = d >= 0 && d % step == 0 && d / step < ncs && cyc <= j_cut;
        cnt = 0;
        if (!j_never)
            for (int k = 0; k < j_n; k++) begin
                r = j_t0 + 4 + k * step + j_lat;
                if (r < cyc && r < j_cut) cnt++;
            end
        if (j_kind == 3 && cyc > j_cut) cnt = 0;
        e_err = j_kind == 2 && cyc > j_cut;
        chk("valid", valid, e_valid);
        chk("busy", busy, e_busy);
        chk("core_start", core_start, e_cs);
        if (cyc > j_t0) begin
            chk("iter_done", iter_done, 192'(cnt));
            chk("error", error, e_err);
        end
        e_sq = last_sq;
        if (e_valid) begin
            vcyc = cyc;
            e_sq = (j_n == 0) ? fmt(j_x) : widen(last_resp);
            if (j_n > 0) chk("sq_reduced", red(sq_out), 192'(pw(j_x, j_n)));
        end
        chk("sq_out", sq_out, e_sq);
        last_sq = e_sq;
        if (core_start) cs_cnt++;
    end

    // kind: 0 plain, 1 abort at t0+off, 3 reset at t0+off. lat 0: core mute.
    task automatic run_job(input int n, input logic [63:0] x, input int lat,
                           input int kind, input int off, input bit bstart,
                           input bit spur);
        int vrel;
        @(negedge clk);
        start = 1'b1;
        iterations = 40'(n);
        sq_in = x;
        j_t0 = cyc; j_n = n; j_x = x; j_lat = lat; j_never = lat == 0;
        j_kind = 0; j_cut = BIG;
        if (lat == 0 && n > 0) begin
            j_kind = 2;
            j_cut = cyc + 4 + TO;
        end
        core_lat = lat; cs_cnt = 0; vcyc = -1;
        spur_at = spur ? cyc + 2 : -1;
        vrel = (j_kind == 2) ? 4 + TO : 4 + n * (lat + 1);
        for (int c = 1; c < vrel + 16; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (c == 1) begin
                iterations = 40'($urandom);
                sq_in = {$urandom, $urandom};
            end
            if (bstart && c == 2) start = 1'b1;
            if (kind == 1 && c == off) begin
                abort = 1'b1;
                j_kind = 1;
                j_cut = cyc;
            end
            if (kind == 3 && c == off) begin
                #2 reset = 1'b0;
                j_kind = 3; j_cut = cyc; last_sq = '0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_valid", valid, 0);
                chk("rst_sq_out", sq_out, 0);
                chk("rst_iter_done", iter_done, 0);
                chk("rst_error", error, 0);
                chk("rst_core_start", core_start, 0);
                chk("rst_core_sq_in", 192'(core_sq_in), 0);
            end
            if (kind == 3 && c == off + 2) #2 reset = 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int n, lat, kind, off;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        iterations = '0;
        sq_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_sq_out", sq_out, 0);
        chk("reset_iter_done", iter_done, 0);
        reset = 1'b1;

        run_job(1, 64'd3, 8, 0, 0, 1'b0, 1'b0);
        chk("t1_latency", 192'(vcyc - j_t0), 192'd13);
        chk("t1_sq_out", sq_out, 192'd9);
        chk("t1_iter_done", iter_done, 192'd1);
        chk("t1_core_starts", 192'(cs_cnt), 192'd1);

        run_job(0, 64'h1234, 8, 0, 0, 1'b0, 1'b1);
        chk("t2_latency", 192'(vcyc - j_t0), 192'd4);
        chk("t2_sq_out", sq_out, 192'h1234);
        chk("t2_core_starts", 192'(cs_cnt), 192'd0);

        run_job(5, 64'd2, 8, 0, 0, 1'b1, 1'b0);
        chk("t3_latency", 192'(vcyc - j_t0), 192'd49);
        chk("t3_reduced", 192'(red(sq_out)), 192'h1_0000_0000);
        chk("t3_iter_done", iter_done, 192'd5);
        chk("t3_core_starts", 192'(cs_cnt), 192'd5);

        run_job(5, 64'd2, 8, 1, 25, 1'b0, 1'b0);
        chk("t4_no_valid", 192'(vcyc), 192'(-1));
        chk("t4_iter_done", iter_done, 192'd2);
        chk("t4_busy", busy, 0);
        run_job(1, 64'd3, 8, 0, 0, 1'b0, 1'b0);
        chk("t4_next_sq_out", sq_out, 192'd9);

        run_job(3, 64'd5, 0, 0, 0, 1'b0, 1'b0);
        chk("t5_error", error, 1);
        chk("t5_busy", busy, 0);
        chk("t5_no_valid", 192'(vcyc), 192'(-1));
        run_job(2, 64'd7, 4, 0, 0, 1'b0, 1'b0);
        chk("t5_error_clr", error, 0);
        chk("t5_reduced", 192'(red(sq_out)), 192'd2401);

        run_job(5, 64'd5, 8, 3, 25, 1'b1, 1'b0);
        chk("t6_iter_done", iter_done, 0);
        chk("t6_sq_out", sq_out, 0);

        for (int i = 0; i < 16; i++) begin
            n = $urandom_range(0, 6);
            lat = $urandom_range(1, 12);
            if ($urandom_range(0, 9) == 0) begin
                lat = 0;
                if (n == 0) n = 1;
            end
            kind = 0;
            off = 0;
            if (lat != 0 && $urandom_range(0, 3) == 0) begin
                kind = 1;
                off = $urandom_range(2, 3 + n * (lat + 1));
            end
            run_job(n, {$urandom, $urandom}, lat, kind, off,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/modular_square_iter_ctrl.md
Name: modular_square_iter_ctrl

Overview:
Parametrised successor to the modular-squaring IO wrapper. It pipes operands into a modular-squaring core and runs a programmable number of back-to-back squarings, feeding each result back as the next operand. It runs on a single clock with no CDC. The core sits outside the block, behind a start/valid port pair, so the controller can be verified standalone. Intended as the VDF evaluation loop controller above the squaring core.

Parameters:
MOD_LEN, 1024, modulus width in bits
WORD_LEN, 16, nonredundant coefficient width
BIT_LEN, 17, core coefficient width (redundant form)
REDUNDANT_ELEMENTS, 2, extra zeroed coefficients
NONREDUNDANT_ELEMENTS, MOD_LEN/WORD_LEN, input coefficients
NUM_ELEMENTS, NONREDUNDANT_ELEMENTS+REDUNDANT_ELEMENTS, total coefficients
IO_STAGES, 3, input register stages, must be >=1
ITER_W, 40, iteration counter width
CORE_TIMEOUT, 1024, max WAIT cycles before error; 0 disables timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  request pulse; sampled only when busy=0
iterations  in  ITER_W  squarings to perform; sampled with start
sq_in  in  MOD_LEN  initial operand
abort  in  1  cancel the current job
busy  out  1  job in progress
valid  out  1  one-cycle result strobe
sq_out  out  NUM_ELEMENTS*32  result; coefficient j in bits [32j+:32], zero-extended from BIT_LEN
iter_done  out  ITER_W  completed squarings in the current or last job
error  out  1  sticky core-timeout flag
core_start  out  1  one-cycle pulse to the core
core_sq_in  out  NUM_ELEMENTS*BIT_LEN  operand to the core
core_sq_out  in  NUM_ELEMENTS*BIT_LEN  core result
core_valid  in  1  core result strobe

Behaviour:
- Reset (reset=0, async): all outputs and state 0, FSM to IDLE, IO pipe cleared.
- Accept: start=1 while busy=0. On accept, busy goes 1 next cycle, iter_done and error clear, and start/iterations/sq_in enter the IO pipe.
- start while busy=1 is ignored entirely.
- Input formatting: coefficient j<NONREDUNDANT_ELEMENTS = sq_in[16j+:16] zero-extended to BIT_LEN; redundant coefficients = 0.
- IO pipe: IO_STAGES register stages. The start flag, iterations and operand travel together.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: when the pipe start emerges, latch operand and iterations. Go to DONE if iterations=0, else to ISSUE.
- ISSUE: core_start=1 for exactly one cycle, core_sq_in = operand register (stable through WAIT), then go to WAIT.
- WAIT: on core_valid, operand <= core_sq_out and iter_done++. Then go to DONE if the new iter_done equals iterations, else to ISSUE.
- DONE: sq_out <= operand and valid=1 for one cycle, then go to IDLE. busy falls in the cycle after valid.
- Latency: with core latency L (core_valid L>=1 cycles after core_start), start in cycle t0 gives valid in cycle t0+IO_STAGES+N*(L+1)+1.
- sq_out holds its value until the next valid; it is unchanged by abort or error.
- core_valid outside WAIT is ignored.
- abort, any non-IDLE state or start in flight: next state is IDLE, pipe start flag is killed, busy=0 next cycle, no valid, iter_done frozen. abort beats core_valid in the same cycle. abort in IDLE with nothing in flight has no effect.
- Timeout: WAIT cycle counter resets on each ISSUE. When it reaches CORE_TIMEOUT without core_valid, error=1 and the FSM goes to IDLE with no valid. error stays 1 until the next accepted start.
- iter_done saturates at iterations and never wraps. iterations = 2^ITER_W-1 is legal.

Test Plan:
1. IO_STAGES=3, core model L=8, iterations=1, sq_in=3 -> valid exactly 13 cycles after start; sq_out coeff0=9, all other coeffs 0; iter_done=1; one core_start pulse.
2. iterations=0, sq_in=0x1234 -> valid 4 cycles after start; coeff0=0x1234; redundant coeffs 0; core_start never asserted.
3. iterations=5, sq_in=2, L=8 -> core_start pulses 5 times, 9 cycles apart; valid 49 cycles after start; reduced sq_out = 2^32; iter_done=5.
4. iterations=5, abort in 3rd WAIT -> busy=0 next cycle, no valid, iter_done=2, a late core_valid is ignored; a new start with iterations=1, sq_in=3 gives 9.
5. CORE_TIMEOUT=16, core never responds -> error=1 and busy=0 after 16 WAIT cycles, no valid; the next start clears error and a normal job completes.
6. start pulsed while busy ignored (iter_done unaffected); reset driven low mid-WAIT -> all outputs 0 immediately, and the core_valid that follows does not change state.
